// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions: arbiter FSM states, bus owner and access size encodings.
package mem_arbiter_pkg;

   localparam int unsigned SIZE_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWNER_INST = 1'b0,
      OWNER_DATA = 1'b1
   } owner_e;

   typedef enum logic [SIZE_W-1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_e;

endpackage

// File: rtl/flopenrc.sv
// Enable/clear flop: async active-high reset, synchronous clear, load on enable.
module flopenrc #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Storage with clear taking precedence over enable
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      q <= '0;
      else if (clear) q <= '0;
      else if (en)    q <= d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch/load-store) arbiter onto a single-outstanding SRAM-like bus.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // fetch port
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   // load/store port
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [SIZE_W-1:0] data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   // bus side
   output logic              bus_req,
   output logic              bus_wr,
   output logic [SIZE_W-1:0] bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              busy
);

   localparam int unsigned CAP_W = 1 + 1 + SIZE_W + ADDR_W + DATA_W;

   arb_state_e        state_q;
   logic              grant_data;
   logic              grant_inst;
   logic              grant;
   logic [CAP_W-1:0]  cap_d;
   logic [CAP_W-1:0]  cap_q;
   owner_e            owner_q;
   logic              done;

   // Arbitration: load/store has fixed priority, only sampled in IDLE
   assign grant_data = (state_q == ST_IDLE) && data_req;
   assign grant_inst = (state_q == ST_IDLE) && !data_req && inst_req;
   assign grant      = grant_data || grant_inst;

   // Fetches are always word reads
   assign cap_d = grant_data ? {OWNER_DATA, data_wr, data_size, data_addr, data_wdata}
                             : {OWNER_INST, 1'b0, SIZE_WORD, inst_addr, {DATA_W{1'b0}}};

   flopenrc #(.WIDTH(CAP_W)) u_cap (
      .clk   (clk),
      .reset (rst),
      .en    (grant),
      .clear (1'b0),
      .d     (cap_d),
      .q     (cap_q)
   );

   assign owner_q = owner_e'(cap_q[CAP_W-1]);
   assign {bus_wr, bus_size, bus_addr, bus_wdata} = cap_q[CAP_W-2:0];

   // Transaction completes on data_ok in DATA, or on a combined handshake in ADDR
   assign done = ((state_q == ST_DATA) && bus_data_ok) ||
                 ((state_q == ST_ADDR) && bus_addr_ok && bus_data_ok);

   // Arbiter FSM: IDLE -> ADDR -> DATA -> IDLE, ADDR may skip DATA
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (grant)       state_q <= ST_ADDR;
            ST_ADDR: if (bus_addr_ok) state_q <= bus_data_ok ? ST_IDLE : ST_DATA;
            ST_DATA: if (bus_data_ok) state_q <= ST_IDLE;
            default:                  state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus_req      = (state_q == ST_ADDR);
   assign busy         = (state_q != ST_IDLE);

   assign inst_addr_ok = grant_inst;
   assign data_addr_ok = grant_data;
   assign inst_data_ok = done && (owner_q == OWNER_INST);
   assign data_data_ok = done && (owner_q == OWNER_DATA);

   assign inst_rdata   = bus_rdata;
   assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, stall, combined handshake, reset.
module tb_mem_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              clk;
   logic              rst;
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_addr_ok;
   logic              inst_data_ok;
   logic [DATA_W-1:0] inst_rdata;
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [DATA_W-1:0] data_rdata;
   logic              bus_req;
   logic              bus_wr;
   logic [1:0]        bus_size;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_addr_ok;
   logic              bus_data_ok;
   logic [DATA_W-1:0] bus_rdata;
   logic              busy;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .bus_req      (bus_req),
      .bus_wr       (bus_wr),
      .bus_size     (bus_size),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_addr_ok  (bus_addr_ok),
      .bus_data_ok  (bus_data_ok),
      .bus_rdata    (bus_rdata),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit past the next rising edge; inputs change there
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs
   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1;
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

      // Reset state
      tick(); tick();
      settle();
      chk("rst_busy",     64'(busy), 64'd0);
      chk("rst_bus_req",  64'(bus_req), 64'd0);
      chk("rst_bus_addr", 64'(bus_addr), 64'd0);
      chk("rst_addr_ok",  64'({inst_addr_ok, data_addr_ok}), 64'd0);
      chk("rst_data_ok",  64'({inst_data_ok, data_data_ok}), 64'd0);
      rst = 1'b0;
      tick();

      // Single fetch
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
      settle();
      chk("f_inst_addr_ok", 64'(inst_addr_ok), 64'd1);
      chk("f_data_addr_ok", 64'(data_addr_ok), 64'd0);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b1;
      settle();
      chk("f_busy",     64'(busy), 64'd1);
      chk("f_bus_req",  64'(bus_req), 64'd1);
      chk("f_bus_addr", 64'(bus_addr), 64'hBFC0_0000);
      chk("f_bus_wr",   64'(bus_wr), 64'd0);
      chk("f_bus_size", 64'(bus_size), 64'd2);
      chk("f_no_early_data_ok", 64'(inst_data_ok), 64'd0);
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2408_0001;
      settle();
      chk("f_data_bus_req",  64'(bus_req), 64'd0);
      chk("f_inst_data_ok",  64'(inst_data_ok), 64'd1);
      chk("f_inst_rdata",    64'(inst_rdata), 64'h2408_0001);
      chk("f_data_data_ok",  64'(data_data_ok), 64'd0);
      tick();
      bus_data_ok = 1'b0;
      settle();
      chk("f_idle_busy",     64'(busy), 64'd0);
      chk("f_idle_data_ok",  64'(inst_data_ok), 64'd0);

      // Simultaneous requests: data wins, then stalled address phase
      inst_req = 1'b1; inst_addr = 32'h1FC0_0010;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
      data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AB;
      settle();
      chk("p_data_addr_ok", 64'(data_addr_ok), 64'd1);
      chk("p_inst_addr_ok", 64'(inst_addr_ok), 64'd0);
      tick();
      data_req = 1'b0; data_addr = 32'h0; data_wdata = 32'h0; data_wr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("s_bus_req",  64'(bus_req), 64'd1);
         chk("s_bus_addr", 64'(bus_addr), 64'h8000_0003);
         chk("s_busy",     64'(busy), 64'd1);
         chk("s_no_grant", 64'({inst_addr_ok, data_addr_ok}), 64'd0);
         tick();
      end
      chk("p_bus_wr",    64'(bus_wr), 64'd1);
      chk("p_bus_size",  64'(bus_size), 64'd0);
      chk("p_bus_wdata", 64'(bus_wdata), 64'hAB);
      bus_addr_ok = 1'b1;
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0055;
      settle();
      chk("p_data_data_ok", 64'(data_data_ok), 64'd1);
      chk("p_inst_data_ok", 64'(inst_data_ok), 64'd0);
      chk("p_data_rdata",   64'(data_rdata), 64'h55);
      chk("p_inst_wait",    64'(inst_addr_ok), 64'd0);
      tick();
      bus_data_ok = 1'b0;
      settle();
      chk("p_inst_grant_next_idle", 64'(inst_addr_ok), 64'd1);
      chk("p_idle_busy",            64'(busy), 64'd0);
      tick();
      inst_req = 1'b0;

      // Combined handshake on the fetch in ADDR
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0000_1234;
      settle();
      chk("c_bus_addr",     64'(bus_addr), 64'h1FC0_0010);
      chk("c_bus_size",     64'(bus_size), 64'd2);
      chk("c_inst_data_ok", 64'(inst_data_ok), 64'd1);
      chk("c_data_data_ok", 64'(data_data_ok), 64'd0);
      tick();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      settle();
      chk("c_idle_busy",    64'(busy), 64'd0);
      chk("c_idle_data_ok", 64'(inst_data_ok), 64'd0);

      // Stray data_ok in IDLE is ignored
      bus_data_ok = 1'b1;
      settle();
      chk("i_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
      tick();
      bus_data_ok = 1'b0;
      settle();
      chk("i_busy", 64'(busy), 64'd0);

      // Reset while in DATA abandons the transaction
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h0000_0010;
      settle();
      chk("r_data_addr_ok", 64'(data_addr_ok), 64'd1);
      tick();
      data_req = 1'b0; bus_addr_ok = 1'b1;
      settle();
      chk("r_bus_size", 64'(bus_size), 64'd1);
      tick();
      bus_addr_ok = 1'b0;
      settle();
      chk("r_in_data_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      settle();
      chk("r_async_busy",     64'(busy), 64'd0);
      chk("r_async_bus_req",  64'(bus_req), 64'd0);
      chk("r_async_bus_addr", 64'(bus_addr), 64'd0);
      tick();
      rst = 1'b0; bus_data_ok = 1'b1;
      settle();
      chk("r_post_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
      chk("r_post_busy",    64'(busy), 64'd0);
      chk("r_post_bus_req", 64'(bus_req), 64'd0);
      tick();
      bus_data_ok = 1'b0;
      settle();
      chk("r_final_busy", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
